// File: rtl/intr_ctrl.sv
// Prioritised, nestable interrupt controller: synchronises request lines, latches edges,
// applies mask and in-service priority, and exposes MASK/EDGE/PEND/VEC on a register port.
module intr_ctrl #(
  parameter int N = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_irq_in,
  output logic          o_irq,
  input  logic          i_inta,
  input  logic          i_sel,
  input  logic          i_we,
  input  logic [1:0]    i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  r_s1;
  logic [N-1:0]  r_s2;
  logic [N-1:0]  r_s3;
  logic [N-1:0]  r_mask;
  logic [N-1:0]  r_edge;
  logic [N-1:0]  r_pend_lat;
  logic [N-1:0]  r_isr;
  logic [IW-1:0] r_cand_q;
  logic          r_irq_q;

  logic [N-1:0]  w_rise;
  logic [N-1:0]  w_pend;
  logic [N-1:0]  w_isr_low;
  logic [N-1:0]  w_prio;
  logic [N-1:0]  w_elig;
  logic [IW-1:0] w_isr_id;
  logic [IW-1:0] w_cand;
  logic          w_wr;
  logic          w_wr_mask;
  logic          w_wr_edge;
  logic          w_wr_pend;
  logic          w_eoi;
  logic          w_ack;
  logic [N-1:0]  w_ack_vec;
  logic [N-1:0]  w_pend_clr;
  logic [N-1:0]  w_isr_after_eoi;
  logic          w_unused;

  assign w_rise = r_s2 & ~r_s3;
  assign w_pend = (r_edge & r_pend_lat) | (~r_edge & r_s3);

  // Lowest set ISR bit as one-hot; everything below it (higher priority) may preempt.
  assign w_isr_low = r_isr & (~r_isr + N'(1));
  assign w_prio    = (r_isr == '0) ? '1 : (w_isr_low - N'(1));
  assign w_elig    = w_pend & r_mask & w_prio;

  always_comb begin
    w_isr_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_isr[i]) w_isr_id = IW'(i);
    end
  end

  always_comb begin
    w_cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_elig[i]) w_cand = IW'(i);
    end
  end

  assign w_wr      = i_sel & i_we;
  assign w_wr_mask = w_wr & (i_addr == 2'd0);
  assign w_wr_edge = w_wr & (i_addr == 2'd1);
  assign w_wr_pend = w_wr & (i_addr == 2'd2);
  assign w_eoi     = w_wr & (i_addr == 2'd3);

  // The acknowledge trusts the registered candidate even if the request has since gone away.
  assign w_ack     = i_inta & r_irq_q;
  assign w_ack_vec = w_ack ? (N'(1) << r_cand_q) : '0;

  assign w_pend_clr      = (w_wr_pend ? i_wdata[N-1:0] : '0) | (w_ack_vec & r_edge);
  assign w_isr_after_eoi = w_eoi ? (r_isr & ~w_isr_low) : r_isr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_s3       <= '0;
      r_mask     <= '0;
      r_edge     <= '0;
      r_pend_lat <= '0;
      r_isr      <= '0;
      r_cand_q   <= '0;
      r_irq_q    <= 1'b0;
    end else begin
      r_s1 <= i_irq_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (w_wr_mask) r_mask <= i_wdata[N-1:0];
      if (w_wr_edge) r_edge <= i_wdata[N-1:0];
      // A fresh rise wins over any clear in the same cycle.
      r_pend_lat <= (w_rise & r_edge) | (r_pend_lat & ~w_pend_clr);
      r_isr      <= w_isr_after_eoi | w_ack_vec;
      r_cand_q   <= w_cand;
      r_irq_q    <= i_inta ? 1'b0 : (|w_elig);
    end
  end

  assign o_irq = r_irq_q;

  always_comb begin
    o_rdata = '0;
    if (i_sel && !i_we) begin
      case (i_addr)
        2'd0: o_rdata[N-1:0] = r_mask;
        2'd1: o_rdata[N-1:0] = r_edge;
        2'd2: o_rdata[N-1:0] = w_pend;
        default: begin
          o_rdata[31]  = |r_isr;
          o_rdata[4:0] = 5'(w_isr_id);
        end
      endcase
    end
  end

  assign w_unused = ^i_wdata[31:N];

endmodule
